// File: rtl/simple_rng.sv
// simple_rng: 32-bit Galois LFSR whose output bits are harvested into a
// NUM_BITS-wide word; a read strobe latches the word once NUM_BITS fresh
// bits have been collected since the last read, reseed or reset.
module simple_rng #(
  parameter int unsigned NUM_BITS = 32,
  parameter logic [31:0] SEED     = 32'hACE1_ACE1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                enable,
  input  logic                dat_we,
  input  logic                dat_re,
  input  logic [NUM_BITS-1:0] dat_di,
  output logic [NUM_BITS-1:0] dat_do,
  output logic                dat_wait
);

  localparam int unsigned LFSR_W   = 32;
  localparam int unsigned CNT_W    = $clog2(NUM_BITS + 1);
  localparam int unsigned DI_EXT_W = (NUM_BITS > LFSR_W) ? NUM_BITS : LFSR_W;
  localparam logic [LFSR_W-1:0] POLY     = 32'h8020_0003;
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(NUM_BITS);

  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [NUM_BITS-1:0] harvest_q, harvest_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ready_q, ready_d;
  logic [NUM_BITS-1:0] dat_do_q, dat_do_d;
  logic                dat_wait_q, dat_wait_d;

  logic [DI_EXT_W-1:0] di_ext;
  logic [LFSR_W-1:0]   seed_ld;
  logic [LFSR_W-1:0]   lfsr_step;
  logic                out_bit;
  logic                rd_ok;

  // Seed value: zero-extend or truncate to the LFSR width, never load zero.
  assign di_ext  = DI_EXT_W'(dat_di);
  assign seed_ld = (di_ext[LFSR_W-1:0] == '0) ? SEED : di_ext[LFSR_W-1:0];

  // One right-shifting Galois step.
  assign out_bit   = lfsr_q[0];
  assign lfsr_step = (lfsr_q >> 1) ^ (out_bit ? POLY : '0);
  assign rd_ok     = dat_re & ready_q;

  // Next-state: reseed beats read/step; a read restarts the bit count.
  always_comb begin
    lfsr_d     = lfsr_q;
    harvest_d  = harvest_q;
    cnt_d      = cnt_q;
    ready_d    = ready_q;
    dat_do_d   = dat_do_q;
    dat_wait_d = dat_wait_q;

    if (dat_we) begin
      lfsr_d    = seed_ld;
      harvest_d = '0;
      cnt_d     = '0;
      ready_d   = 1'b0;
    end else begin
      if (rd_ok) begin
        dat_do_d = harvest_q;
        cnt_d    = '0;
      end
      if (enable) begin
        lfsr_d    = lfsr_step;
        harvest_d = {harvest_q[NUM_BITS-2:0], out_bit};
        if (cnt_d != CNT_FULL) begin
          cnt_d = cnt_d + CNT_W'(1);
        end
      end
      ready_d = (cnt_d == CNT_FULL);
    end
    dat_wait_d = ~ready_d;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (resetn) begin
      lfsr_q     <= SEED;
      harvest_q  <= '0;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      dat_do_q   <= '0;
      dat_wait_q <= 1'b1;
    end else begin
      lfsr_q     <= lfsr_d;
      harvest_q  <= harvest_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      dat_do_q   <= dat_do_d;
      dat_wait_q <= dat_wait_d;
    end
  end

  assign dat_do   = dat_do_q;
  assign dat_wait = dat_wait_q;

endmodule

// File: tb/tb_simple_rng.sv
// Scoreboard bench for simple_rng: stimulus pushes expected outputs from a
// bit-stream reference model, a monitor pops and compares after each edge.
module tb_simple_rng;

  localparam int unsigned N    = 32;
  localparam logic [31:0] SEED = 32'hACE1_ACE1;
  localparam logic [31:0] POLY = 32'h8020_0003;

  logic          clk;
  logic          resetn;
  logic          enable;
  logic          dat_we;
  logic          dat_re;
  logic [N-1:0]  dat_di;
  logic [N-1:0]  dat_do;
  logic          dat_wait;

  simple_rng #(.NUM_BITS(N), .SEED(SEED)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .enable  (enable),
    .dat_we  (dat_we),
    .dat_re  (dat_re),
    .dat_di  (dat_di),
    .dat_do  (dat_do),
    .dat_wait(dat_wait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] do_v;
    logic         wait_v;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: the generator is a stream of output bits; a word is the
  // last N bits of that stream, available once N fresh bits have arrived.
  logic [31:0]  m_lfsr;
  bit           m_hist[$];
  int           m_fresh;
  logic [N-1:0] m_do;

  function automatic logic [N-1:0] pack_hist();
    logic [N-1:0] w = '0;
    foreach (m_hist[i]) w = {w[N-2:0], 1'(m_hist[i])};
    return w;
  endfunction

  task automatic model_edge(input logic rst, input logic en, input logic we,
                            input logic re, input logic [31:0] di);
    bit b;
    if (rst) begin
      m_lfsr = SEED; m_hist.delete(); m_fresh = 0; m_do = '0;
    end else if (we) begin
      m_lfsr = (di == 32'd0) ? SEED : di;
      m_hist.delete(); m_fresh = 0;
    end else begin
      if (re && m_fresh >= int'(N)) begin
        m_do = pack_hist();
        m_fresh = 0;
      end
      if (en) begin
        b = m_lfsr[0];
        m_lfsr = (m_lfsr >> 1) ^ (b ? POLY : 32'd0);
        m_hist.push_back(b);
        if (m_hist.size() > int'(N)) void'(m_hist.pop_front());
        m_fresh++;
      end
    end
  endtask

  // Apply one cycle of inputs, record the expected post-edge outputs.
  task automatic drive(input logic rst, input logic en, input logic we,
                       input logic re, input logic [31:0] di);
    exp_t e;
    resetn = rst; enable = en; dat_we = we; dat_re = re; dat_di = di;
    model_edge(rst, en, we, re, di);
    e.do_v   = m_do;
    e.wait_v = (m_fresh >= int'(N)) ? 1'b0 : 1'b1;
    sb_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare DUT outputs after every edge against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        total++;
        if (dat_do !== e.do_v || dat_wait !== e.wait_v) begin
          bad++;
          $display("FAIL scoreboard t=%0t: dat_do=%h dat_wait=%b expected dat_do=%h dat_wait=%b",
                   $time, dat_do, dat_wait, e.do_v, e.wait_v);
        end
      end
    end
  end

  logic [N-1:0] w_run1;
  int           guard;

  initial begin
    // Reset and first word; a read attempt while waiting must be ignored.
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    chk("reset_do", 64'(dat_do), 64'(0));
    chk("reset_wait", 64'(dat_wait), 64'(1));
    for (int i = 0; i < 32; i++) begin
      drive(0, 1, 0, (i == 5) ? 1'b1 : 1'b0, 0);
      if (i == 5) begin
        chk("early_read_do", 64'(dat_do), 64'(0));
        chk("early_read_wait", 64'(dat_wait), 64'(1));
      end
      if (i == 30) chk("wait_edge31", 64'(dat_wait), 64'(1));
      if (i == 31) chk("wait_edge32", 64'(dat_wait), 64'(0));
    end
    chk("do_before_read", 64'(dat_do), 64'(0));
    drive(0, 0, 0, 1, 0);
    w_run1 = dat_do;
    chk("wait_after_read", 64'(dat_wait), 64'(1));

    // Seed 1: first output bits 1,1,0,1 land in the word's top nibble.
    drive(0, 1, 1, 0, 32'h1);
    for (int i = 0; i < 32; i++) drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    chk("seed1_top_nibble", 64'(dat_do[31:28]), 64'(4'hD));
    chk("seed1_wait_after", 64'(dat_wait), 64'(1));

    // Zero seed falls back to SEED, reproducing the post-reset word.
    drive(0, 1, 1, 0, 32'h0);
    for (int i = 0; i < 32; i++) drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    chk("zero_seed_word", 64'(dat_do), 64'(w_run1));

    // Pause mid-word; reads during the pause are ignored.
    for (int i = 0; i < 10; i++) drive(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0);
    chk("pause_do_frozen", 64'(dat_do), 64'(w_run1));
    for (int i = 0; i < 21; i++) drive(0, 1, 0, 0, 0);
    chk("pause_wait_21", 64'(dat_wait), 64'(1));
    drive(0, 1, 0, 0, 0);
    chk("pause_wait_22", 64'(dat_wait), 64'(0));

    // Mid-run reset restarts the sequence from SEED.
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) drive(0, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    for (int i = 0; i < 32; i++) drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    chk("rerun_word", 64'(dat_do), 64'(w_run1));

    // Simultaneous write and read: reseed only, read dropped.
    for (int i = 0; i < 32; i++) drive(0, 1, 0, 0, 0);
    drive(0, 1, 1, 1, 32'h1234_5678);
    chk("we_re_do_held", 64'(dat_do), 64'(w_run1));
    chk("we_re_wait", 64'(dat_wait), 64'(1));

    // Randomised traffic.
    for (int i = 0; i < 2000; i++) begin
      logic r_rst, r_en, r_we, r_re;
      logic [31:0] r_di;
      r_rst = ($urandom_range(0, 199) == 0);
      r_en  = ($urandom_range(0, 3) != 0);
      r_we  = ($urandom_range(0, 79) == 0);
      r_re  = ($urandom_range(0, 4) == 0);
      r_di  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      drive(r_rst, r_en, r_we, r_re, r_di);
    end
    drive(0, 0, 0, 0, 0);

    guard = 0;
    while (sb_q.size() > 0 && guard < 10) begin
      @(posedge clk); #3;
      guard++;
    end
    if (sb_q.size() > 0) begin
      total++; bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/simple_rng.md
SIMPLE_RNG -- requirements
Module: simple_rng

Interface
REQ-001 Parameters SHALL be as follows.
- NUM_BITS, default 32: width of dat_di/dat_do; legal range 8..64.
- SEED, default 32'hACE1_ACE1: nonzero 32-bit LFSR reset/seed value.

REQ-002 Ports SHALL be as follows (name, direction, width, meaning).
- clk, input, 1: single clock; all state changes on rising edge.
- resetn, input, 1: synchronous, active-high reset (asserted when 1), sampled on rising clk.
- enable, input, 1: 1 = generator advances one step per clock; 0 = generator frozen.
- dat_we, input, 1: seed write strobe.
- dat_re, input, 1: read strobe, latches a fresh random word.
- dat_di, input, NUM_BITS: seed data.
- dat_do, output, NUM_BITS: registered random word.
- dat_wait, output, 1: 1 = no fresh word available yet.

Function
REQ-003 The core SHALL be a 32-bit right-shifting Galois LFSR with mask 32'h8020_0003 (x^32+x^22+x^2+x+1).
- Each step takes out_bit = state[0].
- state <= (state>>1) ^ (out_bit ? 32'h8020_0003 : 0).

REQ-004 In a cycle with enable=1, resetn=0 and dat_we=0, the block SHALL perform exactly one LFSR step.
- The harvest register SHALL shift: harvest <= {harvest[NUM_BITS-2:0], out_bit}.
- The bit counter SHALL increment, saturating at NUM_BITS.

REQ-005 A ready flag SHALL set on the same edge the counter reaches NUM_BITS; dat_wait SHALL equal ~ready, driven from a register.

REQ-006 Once ready=1, the LFSR SHALL keep stepping and the harvest register SHALL keep shifting while enable=1, so a read returns the most recent NUM_BITS output bits.

REQ-007 dat_re=1 on a rising edge with ready=1 SHALL perform the following.
- dat_do <= harvest value before this edge's shift.
- Clear ready and the counter; the step that cycle counts as bit 1 of the next word.

REQ-008 dat_re=1 with ready=0 SHALL be ignored; dat_do holds its value.

REQ-009 dat_we=1 SHALL perform the following on that edge.
- Load the LFSR with dat_di zero-extended/truncated to 32 bits, or SEED if that value is 0.
- Clear the counter, ready and harvest; no LFSR step that cycle.
- Leave dat_do unchanged.

REQ-010 Priority SHALL be resetn > dat_we > dat_re/step; a simultaneous dat_we and dat_re SHALL drop the read.

REQ-011 With enable=0, the LFSR, harvest and counter SHALL hold.
- dat_re SHALL still be honoured if ready=1.
- dat_we SHALL still reseed.

REQ-012 dat_do SHALL change only on a successful read or on reset.

REQ-013 The LFSR state SHALL never become zero.

Reset
REQ-014 On a rising edge with resetn=1, the block SHALL set the following.
- LFSR = SEED; harvest = 0; counter = 0; ready = 0.
- dat_do = 0; dat_wait = 1.

REQ-015 Reset asserted mid-operation SHALL abandon any partial word; the sequence SHALL restart from SEED, identical to that after the first reset.

Verification
REQ-016 Reset, then enable=1 held -> dat_wait=1 for the first 31 edges and falls at the 32nd enabled edge (NUM_BITS=32); dat_do=0 throughout.

REQ-017 dat_re pulse while dat_wait=1 -> dat_do stays 0, dat_wait stays 1.

REQ-018 dat_we with dat_di=32'h1, then enable for 32 cycles, then dat_re -> first LFSR states are 8020_0003, C030_0002, 6018_0001, B02C_0003; dat_do[31:28]=4'hD; dat_wait=1 the cycle after the read.

REQ-019 dat_we with dat_di=0 -> the subsequent dat_do equals the word produced after reset (SEED used).

REQ-020 enable=0 for 3 cycles mid-word -> counter and dat_do frozen; resuming completes the word after exactly the remaining bit count.

REQ-021 Two runs of reset, 32 enabled cycles and a read, the second run preceded by a mid-run reset -> identical dat_do values; dat_we and dat_re asserted together -> reseed only, dat_do unchanged.
